alu_resp_tx: RTL and testbench



---
 rtl/alu_uart_pkg.sv | 23 ++
 rtl/alu_resp_tx.sv | 155 +++++++++++++++
 tb/tb_alu_resp_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: types and constants shared by the UART ALU framers.
// Holds the framer state enum, header byte indices and the opcode type.
package alu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CSUM
    } state_t;

    // Opcode as seen by both the command parser and the response framer
    typedef logic [7:0] opcode_t;

    localparam logic [3:0] HDR_OPCODE = 4'd0;
    localparam logic [3:0] HDR_RSVD   = 4'd1;
    localparam logic [3:0] HDR_LEN_LO = 4'd2;
    localparam logic [3:0] HDR_LEN_HI = 4'd3;
    localparam logic [3:0] PAY_BASE   = 4'd4;

    localparam logic [7:0] RESERVED_BYTE = 8'h00;

endpackage

// File: rtl/alu_resp_tx.sv
// alu_resp_tx: frames one ALU result into a byte-stream response packet.
// Packet: opcode, 0x00, LEN lo, LEN hi, result bytes LSB first[, XOR trailer].
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   res_valid_i/opcode_i/result_i, res_ready_o   result input handshake
//   m_axis_tdata/tvalid/tready                   byte stream to uart_tx
//   busy_o            packet in flight
// Optional build macro ALU_RESP_CHECKSUM_EN appends an XOR trailer byte.
module alu_resp_tx
    import alu_uart_pkg::*;
#(
    parameter int RESULT_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [7:0]                opcode_i,
    input  logic [RESULT_BYTES*8-1:0] result_i,
    output logic [7:0]                m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy_o
);

`ifdef ALU_RESP_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    localparam int LEN_BYTES = 4 + RESULT_BYTES + CSUM_BYTES;
    localparam logic [15:0] LEN16 = 16'(LEN_BYTES);
    localparam logic [3:0] LAST_PAY = 4'(4 + RESULT_BYTES - 1);

    state_t                    r_state;
    logic [3:0]                r_cnt;
    opcode_t                   r_opcode;
    logic [RESULT_BYTES*8-1:0] r_result;
    logic                      r_tvalid;
`ifdef ALU_RESP_CHECKSUM_EN
    logic [7:0]                r_csum;
`endif

    logic                      w_accept;
    logic                      w_hs;
    logic [3:0]                w_pidx;
    logic [7:0]                w_pay;
    logic [7:0]                w_byte;

    assign res_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign w_accept      = res_valid_i & res_ready_o;
    assign w_hs          = r_tvalid & m_axis_tready;
    assign m_axis_tvalid = r_tvalid;
    // Zero when idle so the bus is quiet between packets
    assign m_axis_tdata  = r_tvalid ? w_byte : 8'h00;
    assign w_pidx        = r_cnt - PAY_BASE;

    always_comb begin
        w_pay = 8'h00;
        for (int i = 0; i < RESULT_BYTES; i++) begin
            if (w_pidx == 4'(i)) begin
                w_pay = r_result[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        unique case (1'b1)
            (r_cnt == HDR_OPCODE): w_byte = r_opcode;
            (r_cnt == HDR_RSVD):   w_byte = RESERVED_BYTE;
            (r_cnt == HDR_LEN_LO): w_byte = LEN16[7:0];
            (r_cnt == HDR_LEN_HI): w_byte = LEN16[15:8];
`ifdef ALU_RESP_CHECKSUM_EN
            (r_cnt > LAST_PAY):    w_byte = r_csum;
`endif
            default:               w_byte = w_pay;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_opcode <= '0;
            r_result <= '0;
            r_tvalid <= 1'b0;
`ifdef ALU_RESP_CHECKSUM_EN
            r_csum   <= 8'h00;
`endif
        end else begin
`ifdef ALU_RESP_CHECKSUM_EN
            // Running XOR of every byte already handed to uart_tx
            if (w_hs) begin
                r_csum <= r_csum ^ w_byte;
            end
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opcode <= opcode_i;
                        r_result <= result_i;
                        r_cnt    <= 4'd0;
                        r_tvalid <= 1'b1;
                        r_state  <= HEADER;
`ifdef ALU_RESP_CHECKSUM_EN
                        r_csum   <= 8'h00;
`endif
                    end
                end
                HEADER: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == HDR_LEN_HI) begin
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_hs) begin
                        if (r_cnt == LAST_PAY) begin
`ifdef ALU_RESP_CHECKSUM_EN
                            r_cnt    <= r_cnt + 4'd1;
                            r_state  <= CSUM;
`else
                            r_cnt    <= 4'd0;
                            r_tvalid <= 1'b0;
                            r_state  <= IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
`ifdef ALU_RESP_CHECKSUM_EN
                CSUM: begin
                    if (w_hs) begin
                        r_cnt    <= 4'd0;
                        r_tvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
`endif
                default: begin
                    r_cnt    <= 4'd0;
                    r_tvalid <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_resp_tx.sv
// tb_alu_resp_tx: directed bench for the ALU response framer.
// Checks reset, framing, backpressure, busy input, back-to-back and reset.
module tb_alu_resp_tx;

`ifdef ALU_RESP_CHECKSUM_EN
    localparam int LEN = 9;
`else
    localparam int LEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid_i;
    logic        res_ready_o;
    logic [7:0]  opcode_i;
    logic [31:0] result_i;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] mon_b[$];
    int         mon_c[$];
    logic [7:0] exp_b[$];

    alu_resp_tx #(.RESULT_BYTES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .opcode_i      (opcode_i),
        .result_i      (result_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so negedge sees what the next edge will
    always @(negedge clk) begin
        cyc++;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            mon_b.push_back(m_axis_tdata);
            mon_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input logic [7:0] op, input logic [31:0] res);
        logic [7:0] p[$];
        logic [7:0] x;
        p = '{op, 8'h00, 8'(LEN), 8'h00,
              res[7:0], res[15:8], res[23:16], res[31:24]};
`ifdef ALU_RESP_CHECKSUM_EN
        x = 8'h00;
        foreach (p[i]) x = x ^ p[i];
        p.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (p[i]) exp_b.push_back(p[i]);
    endtask

    task automatic wait_hs(input int n, input int budget);
        for (int i = 0; i < budget && mon_b.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("hs_timeout", 32'(mon_b.size() >= n), 32'd1);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, 32'(mon_b.size()), 32'(exp_b.size()));
        foreach (exp_b[i]) begin
            if (i < mon_b.size()) begin
                chk($sformatf("%s_b%0d", tag, i), 32'(mon_b[i]),
                    32'(exp_b[i]));
            end
        end
    endtask

    task automatic clr();
        mon_b.delete();
        mon_c.delete();
        exp_b.delete();
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] res);
        @(posedge clk);
        #1;
        res_valid_i = 1'b1;
        opcode_i    = op;
        result_i    = res;
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        res_valid_i   = 1'b0;
        opcode_i      = 8'h00;
        result_i      = 32'h0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 32'(res_ready_o), 32'd1);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'h00);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // Basic packet, tready always high
        clr();
        add_pkt(8'h03, 32'hDEADBEEF);
        send(8'h03, 32'hDEADBEEF);
        chk("lat_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("lat_tdata", 32'(m_axis_tdata), 32'h03);
        chk("lat_ready", 32'(res_ready_o), 32'd0);
        chk("lat_busy", 32'(busy_o), 32'd1);
        wait_hs(LEN, 50);
        chk("basic_ready_last", 32'(res_ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("basic_ready_after", 32'(res_ready_o), 32'd1);
        chk("basic_busy_after", 32'(busy_o), 32'd0);
        chk("basic_tvalid_after", 32'(m_axis_tvalid), 32'd0);
        chk_seq("basic");
        if (mon_c.size() == LEN) begin
            chk("basic_consec", 32'(mon_c[LEN-1] - mon_c[0]), 32'(LEN-1));
        end

        // Backpressure at byte 2
        clr();
        add_pkt(8'h03, 32'hDEADBEEF);
        send(8'h03, 32'hDEADBEEF);
        wait_hs(2, 50);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_tdata%0d", i), 32'(m_axis_tdata), 32'h08);
            chk($sformatf("bp_tvalid%0d", i), 32'(m_axis_tvalid), 32'd1);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_hs(LEN, 50);
        chk_seq("bp");

        // Result offered while busy is dropped
        @(posedge clk);
        #1;
        clr();
        add_pkt(8'h03, 32'hDEADBEEF);
        send(8'h03, 32'hDEADBEEF);
        wait_hs(5, 50);
        @(posedge clk);
        #1;
        res_valid_i = 1'b1;
        opcode_i    = 8'h55;
        result_i    = 32'h11223344;
        chk("busy_ready", 32'(res_ready_o), 32'd0);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        wait_hs(LEN, 50);
        repeat (6) @(posedge clk);
        #1;
        chk_seq("busy");
        chk("busy_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Back-to-back with valid held
        clr();
        add_pkt(8'h03, 32'hCAFEF00D);
        add_pkt(8'h07, 32'h01020304);
        @(posedge clk);
        #1;
        res_valid_i = 1'b1;
        opcode_i    = 8'h03;
        result_i    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        opcode_i = 8'h07;
        result_i = 32'h01020304;
        wait_hs(LEN + 1, 60);
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        wait_hs(2 * LEN, 60);
        chk_seq("b2b");
        if (mon_c.size() == 2 * LEN) begin
            chk("b2b_gap", 32'(mon_c[LEN] - mon_c[LEN-1]), 32'd2);
        end

        // Reset while byte 4 is on the bus
        @(posedge clk);
        #1;
        clr();
        send(8'h03, 32'hDEADBEEF);
        wait_hs(4, 50);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        m_axis_tready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mrst_ready", 32'(res_ready_o), 32'd1);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mrst_no_bytes", 32'(mon_b.size()), 32'd4);
        clr();
        add_pkt(8'h0A, 32'h89ABCDEF);
        send(8'h0A, 32'h89ABCDEF);
        wait_hs(LEN, 50);
        chk_seq("mrst_next");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
